// File: rtl/rggen_external_register_bridge_if.sv
// Shared bus types plus the local register-bus and external-bus interfaces
// used by the external register bridge.
package rggen_rtl_pkg;
  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  // Numeric order doubles as severity order: error > EXOKAY > OKAY.
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;
endpackage

interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  import rggen_rtl_pkg::*;

  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      select;
  logic                      ready;
  rggen_status               status;
  logic [DATA_WIDTH-1:0]     read_data;
  logic [DATA_WIDTH-1:0]     value;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  select, ready, status, read_data, value
  );
  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output select, ready, status, read_data, value
  );
endinterface

interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  import rggen_rtl_pkg::*;

  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  rggen_status               status;
  logic [DATA_WIDTH-1:0]     read_data;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, status, read_data
  );
  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, status, read_data
  );
endinterface

// File: rtl/rggen_external_register_bridge.sv
// Bridges one local register access onto a possibly narrower external bus as
// LSB-first beats, with strobe-based beat skipping, error abort and timeout.
module rggen_external_register_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH       = 16,
  parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS       = '0,
  parameter bit [ADDRESS_WIDTH-1:0] END_ADDRESS         = '0,
  parameter int                     DATA_WIDTH          = 32,
  parameter int                     EXTERNAL_DATA_WIDTH = 32,
  parameter int                     TIMEOUT_CYCLES      = 0
)(
  input logic             clk,
  input logic             rst,
  rggen_register_if.slave register_if,
  rggen_bus_if.master     bus_if
);
  localparam int BEATS     = DATA_WIDTH / EXTERNAL_DATA_WIDTH;
  localparam int EXT_BYTES = EXTERNAL_DATA_WIDTH / 8;
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WINDOW    = int'(END_ADDRESS) - int'(START_ADDRESS) + 1;
  localparam int EXTERNAL_ADDRESS_WIDTH = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EAW       = EXTERNAL_ADDRESS_WIDTH;
  localparam int TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;

  state_e                 state, state_next;
  logic [EAW-1:0]         offset;
  rggen_direction         dir;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [STRB_W-1:0]      strobe;
  logic [DATA_WIDTH-1:0]  acc, acc_upd;
  logic [BEAT_W-1:0]      beat;
  logic [TW-1:0]          tcnt;
  rggen_status            worst, worst_next;

  logic [ADDRESS_WIDTH:0] lo_diff, hi_diff;
  logic                   match, accept, bus_err, expired;
  logic [BEAT_W:0]        first_beat, next_beat;

  function automatic logic [BEATS-1:0] beat_enable(input rggen_direction d,
                                                   input logic [STRB_W-1:0] s);
    logic [BEATS-1:0] en;
    for (int i = 0; i < BEATS; i++)
      en[i] = (d == RGGEN_READ) || (|s[i*EXT_BYTES +: EXT_BYTES]);
    return en;
  endfunction

  // Returns {found, index} of the first enabled beat at or above 'from'.
  function automatic logic [BEAT_W:0] find_beat(input logic [BEATS-1:0] en, input int from);
    logic              found;
    logic [BEAT_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (!found && i >= from && en[i]) begin
        found = 1'b1;
        idx   = BEAT_W'(i);
      end
    end
    return {found, idx};
  endfunction

  // Borrow-out of the two subtractions gives the window check without
  // unsigned compares against a possibly-zero bound.
  assign lo_diff = {1'b0, register_if.address} - {1'b0, START_ADDRESS};
  assign hi_diff = {1'b0, END_ADDRESS} - {1'b0, register_if.address};
  assign match   = ((lo_diff >> ADDRESS_WIDTH) == '0) && ((hi_diff >> ADDRESS_WIDTH) == '0)
                && ((register_if.address % ADDRESS_WIDTH'(STRB_W)) == '0);

  assign register_if.select = match;
  assign register_if.value  = register_if.read_data;

  assign accept     = (state == IDLE) && register_if.request && match;
  assign first_beat = find_beat(beat_enable(register_if.direction, register_if.write_strobe), 0);
  assign next_beat  = find_beat(beat_enable(dir, strobe), int'(beat) + 1);
  assign bus_err    = bus_if.status inside {RGGEN_SLAVE_ERROR, RGGEN_DECODE_ERROR};
  assign expired    = (TIMEOUT_CYCLES > 0) && (tcnt == T_LAST) && !bus_if.done;
  assign worst_next = (bus_if.status > worst) ? bus_if.status : worst;

  always_comb begin
    acc_upd = acc;
    acc_upd[int'(beat)*EXTERNAL_DATA_WIDTH +: EXTERNAL_DATA_WIDTH] = bus_if.read_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = first_beat[BEAT_W] ? ISSUE : RESPOND;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (bus_if.done) state_next = (bus_err || !next_beat[BEAT_W]) ? RESPOND : ISSUE;
        else if (expired) state_next = RESPOND;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_if.request        <= 1'b0;
      bus_if.address        <= '0;
      bus_if.direction      <= RGGEN_READ;
      bus_if.write_data     <= '0;
      bus_if.write_strobe   <= '0;
      register_if.ready     <= 1'b0;
      register_if.read_data <= '0;
      register_if.status    <= RGGEN_OKAY;
      offset                <= '0;
      dir                   <= RGGEN_READ;
      wdata                 <= '0;
      strobe                <= '0;
      acc                   <= '0;
      beat                  <= '0;
      tcnt                  <= '0;
      worst                 <= RGGEN_OKAY;
    end else begin
      case (state)
        IDLE: if (accept) begin
          offset <= EAW'(lo_diff);
          dir    <= register_if.direction;
          wdata  <= register_if.write_data;
          strobe <= register_if.write_strobe;
          acc    <= '0;
          worst  <= RGGEN_OKAY;
          beat   <= first_beat[BEAT_W-1:0];
          // All-zero write strobe: answer immediately without touching the bus.
          if (!first_beat[BEAT_W]) begin
            register_if.ready     <= 1'b1;
            register_if.read_data <= '0;
            register_if.status    <= RGGEN_OKAY;
          end
        end
        ISSUE: begin
          bus_if.request      <= 1'b1;
          bus_if.address      <= EAW'(32'(offset) + 32'(beat) * EXT_BYTES);
          bus_if.direction    <= dir;
          bus_if.write_data   <= wdata[int'(beat)*EXTERNAL_DATA_WIDTH +: EXTERNAL_DATA_WIDTH];
          bus_if.write_strobe <= strobe[int'(beat)*EXT_BYTES +: EXT_BYTES];
          tcnt                <= '0;
        end
        WAIT: begin
          if (bus_if.done) begin
            bus_if.request <= 1'b0;
            if (bus_err) begin
              register_if.ready     <= 1'b1;
              register_if.read_data <= acc;
              register_if.status    <= bus_if.status;
            end else begin
              acc   <= acc_upd;
              worst <= worst_next;
              beat  <= next_beat[BEAT_W-1:0];
              if (!next_beat[BEAT_W]) begin
                register_if.ready     <= 1'b1;
                register_if.read_data <= acc_upd;
                register_if.status    <= worst_next;
              end
            end
          end else if (expired) begin
            bus_if.request        <= 1'b0;
            register_if.ready     <= 1'b1;
            register_if.read_data <= '0;
            register_if.status    <= RGGEN_SLAVE_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: register_if.ready <= 1'b0;
      endcase
    end
  end
endmodule
